gpio_bank: RTL and testbench
============================

GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL expose parameters, one per line: name, default, meaning:
  BASE_ADDR  32'h80000000  byte address of port 0
  NUM_PORTS  2  GPIO ports, 1..4
  PORT_WIDTH  32  bits per port, 1..32
  SYNC_STAGES  2  input synchroniser depth, 2..3
REQ-002 SHALL expose ports, one per line: name, direction, width, meaning:
  clk_i  in  1  single clock
  rst_ni  in  1  reset, synchronous, active-low
  bus_req_i  in  1  request valid
  bus_we_i  in  1  1=write, 0=read
  bus_addr_bi  in  32  byte address
  bus_be_bi  in  4  byte enables
  bus_wdata_bi  in  32  write data
  bus_ack_o  out  1  request accepted
  bus_resp_o  out  1  read data valid
  bus_rdata_bo  out  32  read data
  gpio_bi  in  NUM_PORTS*PORT_WIDTH  pad inputs, port p at [p*PORT_WIDTH +: PORT_WIDTH]
  gpio_bo  out  NUM_PORTS*PORT_WIDTH  pad outputs
  gpio_oe_bo  out  NUM_PORTS*PORT_WIDTH  output enables, 1=drive
  irq_o  out  1  level interrupt

Function
REQ-003 Decode window: BASE_ADDR .. BASE_ADDR+NUM_PORTS*0x20-1; port p = (addr-BASE_ADDR)>>5, offset = addr[4:0].
REQ-004 Per-port offsets: 0x00 OUT rw; 0x04 IN ro; 0x08 DIR rw; 0x0C SET wo; 0x10 CLR wo; 0x14 TGL wo; 0x18 IRQ_EN rw; 0x1C IRQ_STAT w1c.
REQ-005 bus_ack_o = bus_req_i AND address in window, combinational; out-of-window requests never acked, no state change.
REQ-006 Accepted read: bus_resp_o=1 exactly one cycle later, single cycle; bus_rdata_bo valid only then, 0 otherwise.
REQ-007 Reads of wo offsets, unaligned offsets (addr[1:0]!=0) return 0 with resp asserted; no resp for writes.
REQ-008 Writes honour bus_be_bi per byte; bits above PORT_WIDTH ignored on write, read as 0.
REQ-009 SET: OUT|=wdata; CLR: OUT&=~wdata; TGL: OUT^=wdata; effect visible on gpio_bo next cycle.
REQ-010 gpio_bo = OUT registers; gpio_oe_bo = DIR registers; both registered, no combinational path from bus.
REQ-011 IN = gpio_bi after SYNC_STAGES flops; IN read latency from pad to readable = SYNC_STAGES cycles.
REQ-012 Back-to-back accepted requests every cycle supported with no bubbles.

Reset
REQ-013 rst_ni low at clk_i edge: OUT=0, DIR=0, IRQ_EN=0, IRQ_STAT=0, sync flops=0, bus_resp_o=0, bus_rdata_bo=0, irq_o=0.
REQ-014 Read accepted in the cycle reset asserts produces no resp; bus_ack_o stays combinational during reset.
REQ-015 First post-reset cycle SHALL not record an edge from reset-zeroed sync flops.

Configuration
REQ-016 Macro GPIO_BANK_IRQ_EN defined: rising edge on synchronised IN bit sets IRQ_STAT bit; irq_o = OR over ports of (IRQ_STAT & IRQ_EN), registered.
REQ-017 Same-cycle edge and W1C on same bit: set wins.
REQ-018 Macro undefined: no edge/IRQ logic; IRQ_EN, IRQ_STAT read 0, writes ignored; irq_o tied 0.

Structure
REQ-019 Package gpio_bank_pkg SHALL hold offset localparams (GPIO_OFS_OUT..GPIO_OFS_IRQ_STAT) and port-stride constant 0x20.
REQ-020 One sub-module gpio_sync: per-port SYNC_STAGES synchroniser plus rising-edge pulse output, instantiated NUM_PORTS times.

Verification
REQ-021 Write 0x80000000=0x0000_00A5 be=4'hF, read back -> resp 1 cycle after ack, rdata 0x000000A5, gpio_bo[7:0]=0xA5.
REQ-022 OUT=0xF0; SET 0x0F; CLR 0x30; TGL 0x101 -> gpio_bo[31:0] sequence 0xFF, 0xCF, 0x1CE.
REQ-023 Write be=4'b0010 wdata 0xFFFFFFFF to DIR of port 1 (0x80000028) -> gpio_oe_bo[63:32]=0x0000FF00.
REQ-024 Read 0x80000040 with NUM_PORTS=2 -> bus_ack_o=0, no resp, no state change.
REQ-025 IRQ_EN build: IRQ_EN port0=0x1, gpio_bi[0] 0->1 -> IRQ_STAT bit0 set after SYNC_STAGES+1 cycles, irq_o=1; W1C 0x1 -> irq_o=0; repeat with coincident edge -> stays 1.
REQ-026 rst_ni low one cycle mid-stream with OUT=0xFFFFFFFF, pending read -> gpio_bo=0, no resp, irq_o=0 next cycle.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: shared constants for the GPIO bank.
//   - per-port register offsets (byte offset within a 0x20 port stride)
//   - port stride in bytes
//   - byte-enable to bit-mask expansion helper
package gpio_bank_pkg;

    localparam logic [4:0] GPIO_OFS_OUT      = 5'h00;
    localparam logic [4:0] GPIO_OFS_IN       = 5'h04;
    localparam logic [4:0] GPIO_OFS_DIR      = 5'h08;
    localparam logic [4:0] GPIO_OFS_SET      = 5'h0C;
    localparam logic [4:0] GPIO_OFS_CLR      = 5'h10;
    localparam logic [4:0] GPIO_OFS_TGL      = 5'h14;
    localparam logic [4:0] GPIO_OFS_IRQ_EN   = 5'h18;
    localparam logic [4:0] GPIO_OFS_IRQ_STAT = 5'h1C;

    localparam int unsigned GPIO_PORT_STRIDE = 32'h20;

    // Expand 4 byte enables into a 32-bit write mask.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: multi-flop input synchroniser for one GPIO port plus a
// rising-edge pulse on the synchronised value.
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   pad_i   asynchronous pad inputs
//   sync_o  synchronised inputs (SYNC_STAGES flops after pad_i)
//   rise_o  one-cycle pulse on a 0->1 transition of sync_o
module gpio_sync #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0]     stage_q [SYNC_STAGES];
    logic [WIDTH-1:0]     prev_q;
    // Fills with ones after reset; once the top bit is set, both the last
    // stage and prev_q hold real pad samples rather than reset zeros.
    logic [SYNC_STAGES:0] primed_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q   <= '0;
            primed_q <= '0;
        end else begin
            stage_q[0] <= pad_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q   <= stage_q[SYNC_STAGES-1];
            primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];
    assign rise_o = stage_q[SYNC_STAGES-1] & ~prev_q & {WIDTH{primed_q[SYNC_STAGES]}};

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped bank of NUM_PORTS GPIO ports.
//   clk_i, rst_ni           clock, synchronous active-low reset
//   bus_req_i/we_i/addr_bi  request, direction, byte address
//   bus_be_bi/wdata_bi      byte enables, write data
//   bus_ack_o               combinational accept (address in window)
//   bus_resp_o/rdata_bo     read response one cycle after accept
//   gpio_bi/bo/oe_bo        pad inputs, pad outputs, output enables
//   irq_o                   registered level interrupt
// Build option: define GPIO_BANK_IRQ_EN to enable rising-edge interrupts
// (IRQ_EN / IRQ_STAT registers). Without it those read 0 and irq_o is 0.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h80000000,
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned PORT_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            bus_req_i,
    input  logic                            bus_we_i,
    input  logic [31:0]                     bus_addr_bi,
    input  logic [3:0]                      bus_be_bi,
    input  logic [31:0]                     bus_wdata_bi,
    output logic                            bus_ack_o,
    output logic                            bus_resp_o,
    output logic [31:0]                     bus_rdata_bo,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_bi,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_bo,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_oe_bo,
    output logic                            irq_o
);

    localparam logic [31:0] WIN_SIZE = 32'(NUM_PORTS * GPIO_PORT_STRIDE);

    logic [31:0]           off;
    logic [4:0]            reg_ofs;
    logic                  aligned;
    logic                  wr_en;
    logic                  rd_en;
    logic [NUM_PORTS-1:0]  port_sel;
    logic [31:0]           be_bits;
    logic [31:0]           wbits;
    logic [PORT_WIDTH-1:0] wmask;
    logic [PORT_WIDTH-1:0] wval;

    logic [PORT_WIDTH-1:0] out_q  [NUM_PORTS];
    logic [PORT_WIDTH-1:0] out_d  [NUM_PORTS];
    logic [PORT_WIDTH-1:0] dir_q  [NUM_PORTS];
    logic [PORT_WIDTH-1:0] dir_d  [NUM_PORTS];
    logic [PORT_WIDTH-1:0] in_sync[NUM_PORTS];
    logic [PORT_WIDTH-1:0] rise   [NUM_PORTS];

    logic                  resp_q;
    logic [31:0]           rdata_q;
    logic [31:0]           rdata_d;

    // Address decode; addresses below BASE_ADDR wrap to large offsets.
    assign off       = bus_addr_bi - BASE_ADDR;
    assign reg_ofs   = off[4:0];
    assign aligned   = (bus_addr_bi[1:0] == 2'b00);
    assign bus_ack_o = bus_req_i && (off < WIN_SIZE);
    assign wr_en     = bus_ack_o && bus_we_i && aligned;
    assign rd_en     = bus_ack_o && !bus_we_i;

    always_comb begin
        port_sel = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            port_sel[p] = (off[6:5] == 2'(p));
        end
    end

    assign be_bits = be_mask(bus_be_bi);
    assign wbits   = bus_wdata_bi & be_bits;
    assign wmask   = be_bits[PORT_WIDTH-1:0];
    assign wval    = wbits[PORT_WIDTH-1:0];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        gpio_sync #(
            .WIDTH       (PORT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .pad_i  (gpio_bi[g*PORT_WIDTH +: PORT_WIDTH]),
            .sync_o (in_sync[g]),
            .rise_o (rise[g])
        );
        assign gpio_bo[g*PORT_WIDTH +: PORT_WIDTH]    = out_q[g];
        assign gpio_oe_bo[g*PORT_WIDTH +: PORT_WIDTH] = dir_q[g];
    end

`ifdef GPIO_BANK_IRQ_EN
    logic [PORT_WIDTH-1:0] irq_en_q  [NUM_PORTS];
    logic [PORT_WIDTH-1:0] irq_en_d  [NUM_PORTS];
    logic [PORT_WIDTH-1:0] irq_stat_q[NUM_PORTS];
    logic [PORT_WIDTH-1:0] irq_stat_d[NUM_PORTS];
    logic                  irq_q;
    logic                  irq_d;

    // W1C clears first, then edges OR in, so a coincident edge wins.
    always_comb begin
        irq_d = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            irq_en_d[p]   = irq_en_q[p];
            irq_stat_d[p] = irq_stat_q[p];
            if (wr_en && port_sel[p]) begin
                if (reg_ofs == GPIO_OFS_IRQ_EN) begin
                    irq_en_d[p] = (irq_en_q[p] & ~wmask) | wval;
                end
                if (reg_ofs == GPIO_OFS_IRQ_STAT) begin
                    irq_stat_d[p] = irq_stat_q[p] & ~wval;
                end
            end
            irq_stat_d[p] = irq_stat_d[p] | rise[p];
            irq_d = irq_d | (|(irq_stat_q[p] & irq_en_q[p]));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                irq_en_q[p]   <= '0;
                irq_stat_q[p] <= '0;
            end
            irq_q <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                irq_en_q[p]   <= irq_en_d[p];
                irq_stat_q[p] <= irq_stat_d[p];
            end
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_rise;

    always_comb begin
        unused_rise = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            unused_rise = unused_rise | (|rise[p]);
        end
    end

    assign irq_o = 1'b0;
`endif

    // OUT / DIR update and read-data mux.
    always_comb begin
        rdata_d = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            out_d[p] = out_q[p];
            dir_d[p] = dir_q[p];
            if (wr_en && port_sel[p]) begin
                case (reg_ofs)
                    GPIO_OFS_OUT: out_d[p] = (out_q[p] & ~wmask) | wval;
                    GPIO_OFS_DIR: dir_d[p] = (dir_q[p] & ~wmask) | wval;
                    GPIO_OFS_SET: out_d[p] = out_q[p] | wval;
                    GPIO_OFS_CLR: out_d[p] = out_q[p] & ~wval;
                    GPIO_OFS_TGL: out_d[p] = out_q[p] ^ wval;
                    default: ;
                endcase
            end
            if (rd_en && aligned && port_sel[p]) begin
                case (reg_ofs)
                    GPIO_OFS_OUT:      rdata_d = 32'(out_q[p]);
                    GPIO_OFS_IN:       rdata_d = 32'(in_sync[p]);
                    GPIO_OFS_DIR:      rdata_d = 32'(dir_q[p]);
`ifdef GPIO_BANK_IRQ_EN
                    GPIO_OFS_IRQ_EN:   rdata_d = 32'(irq_en_q[p]);
                    GPIO_OFS_IRQ_STAT: rdata_d = 32'(irq_stat_q[p]);
`endif
                    default:           rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                out_q[p] <= '0;
                dir_q[p] <= '0;
            end
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                out_q[p] <= out_d[p];
                dir_q[p] <= dir_d[p];
            end
            resp_q  <= rd_en;
            rdata_q <= rdata_d;
        end
    end

    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank (default parameters). Reads push their
// expected data and issue cycle; a monitor pops on bus_resp_o.
module tb_gpio_bank;

    localparam logic [31:0] A_OUT0  = 32'h80000000;
    localparam logic [31:0] A_IN0   = 32'h80000004;
    localparam logic [31:0] A_SET0  = 32'h8000000C;
    localparam logic [31:0] A_CLR0  = 32'h80000010;
    localparam logic [31:0] A_TGL0  = 32'h80000014;
    localparam logic [31:0] A_IEN0  = 32'h80000018;
    localparam logic [31:0] A_IST0  = 32'h8000001C;
    localparam logic [31:0] A_OUT1  = 32'h80000020;
    localparam logic [31:0] A_IN1   = 32'h80000024;
    localparam logic [31:0] A_DIR1  = 32'h80000028;
    localparam logic [31:0] A_IST1  = 32'h8000003C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;
    logic [63:0] gpio_in;
    logic [63:0] gpio_out;
    logic [63:0] gpio_oe;
    logic        irq;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpio_bank #(
        .BASE_ADDR   (32'h80000000),
        .NUM_PORTS   (2),
        .PORT_WIDTH  (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bus_req_i    (req),
        .bus_we_i     (we),
        .bus_addr_bi  (addr),
        .bus_be_bi    (be),
        .bus_wdata_bi (wdata),
        .bus_ack_o    (ack),
        .bus_resp_o   (resp),
        .bus_rdata_bo (rdata),
        .gpio_bi      (gpio_in),
        .gpio_bo      (gpio_out),
        .gpio_oe_bo   (gpio_oe),
        .irq_o        (irq)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request for one clock; called at a negedge, returns at the next.
    task automatic bus_cycle(input logic w, input logic [31:0] a, input logic [3:0] b,
                             input logic [31:0] d, input logic exp_ack, input logic [31:0] exp_rd);
        exp_t e;
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        #1;
        chk("ack", ack, exp_ack);
        if (!w && exp_ack && rst_n) begin
            e.data = exp_rd;
            e.cyc  = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        bus_cycle(1'b1, a, b, d, 1'b1, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        bus_cycle(1'b0, a, 4'hF, 32'h0, 1'b1, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req = 1'b0;
            @(negedge clk);
        end
    endtask

    // Monitor: pops one expectation per response; flags late/missing ones.
    always @(negedge clk) begin
        exp_t e;
        if (resp) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", resp, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("rdata", rdata, e.data);
                chk("resp_latency", cyc, e.cyc + 1);
            end
        end else begin
            chk("rdata_idle", rdata, 32'h0);
            if (sb.size() > 0 && cyc >= sb[0].cyc + 1) begin
                e = sb.pop_front();
                chk("missing_resp", resp, 1'b1);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        gpio_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_gpio_bo", gpio_out, 64'h0);
        chk("rst_gpio_oe", gpio_oe, 64'h0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_resp", resp, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // Basic write / readback
        wr(A_OUT0, 4'hF, 32'h000000A5);
        chk("out_a5", gpio_out[7:0], 8'hA5);
        rd(A_OUT0, 32'h000000A5);

        // SET / CLR / TGL
        wr(A_OUT0, 4'hF, 32'h000000F0);
        wr(A_SET0, 4'hF, 32'h0000000F);
        chk("set", gpio_out[31:0], 32'h000000FF);
        wr(A_CLR0, 4'hF, 32'h00000030);
        chk("clr", gpio_out[31:0], 32'h000000CF);
        wr(A_TGL0, 4'hF, 32'h00000101);
        chk("tgl", gpio_out[31:0], 32'h000001CE);

        // Byte-enabled DIR write on port 1
        wr(A_DIR1, 4'b0010, 32'hFFFFFFFF);
        chk("dir1_be", gpio_oe[63:32], 32'h0000FF00);
        chk("dir0_untouched", gpio_oe[31:0], 32'h0);

        // Out-of-window: no ack, no resp, no state change
        bus_cycle(1'b0, 32'h80000040, 4'hF, 32'h0, 1'b0, 32'h0);
        bus_cycle(1'b1, 32'h80000040, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0);
        bus_cycle(1'b0, 32'h7FFFFFFC, 4'hF, 32'h0, 1'b0, 32'h0);

        // Back-to-back reads, including write-only and unaligned offsets
        rd(A_OUT0, 32'h000001CE);
        rd(A_DIR1, 32'h0000FF00);
        rd(A_OUT1, 32'h0);
        rd(A_SET0, 32'h0);
        rd(32'h80000001, 32'h0);
        chk("oow_no_change", gpio_out[63:32], 32'h0);

        // Partial byte-enable OUT write, then immediate readback
        wr(A_OUT1, 4'b0101, 32'h11223344);
        chk("out1_be", gpio_out[63:32], 32'h00220044);
        rd(A_OUT1, 32'h00220044);

        // Input synchroniser latency: visible to reads issued 2 cycles later
        gpio_in = {32'hCAFEF00D, 32'h12345678};
        rd(A_IN0, 32'h0);
        rd(A_IN0, 32'h0);
        rd(A_IN0, 32'h12345678);
        rd(A_IN1, 32'hCAFEF00D);

`ifdef GPIO_BANK_IRQ_EN
        wr(A_IEN0, 4'hF, 32'hFFFFFFFF);
        rd(A_IEN0, 32'hFFFFFFFF);
        rd(A_IST0, 32'h12345678);
        chk("irq_pending", irq, 1'b1);
`else
        wr(A_IEN0, 4'hF, 32'hFFFFFFFF);
        rd(A_IEN0, 32'h0);
        rd(A_IST0, 32'h0);
        chk("irq_disabled", irq, 1'b0);
`endif

        // Reset mid-stream with a read accepted in the reset cycle
        wr(A_OUT0, 4'hF, 32'hFFFFFFFF);
        chk("out_ones", gpio_out[31:0], 32'hFFFFFFFF);
        rst_n = 1'b0;
        bus_cycle(1'b0, A_OUT0, 4'hF, 32'h0, 1'b1, 32'h0);
        rst_n = 1'b1;
        chk("midrst_gpio_bo", gpio_out, 64'h0);
        chk("midrst_gpio_oe", gpio_oe, 64'h0);
        chk("midrst_irq", irq, 1'b0);
        chk("midrst_resp", resp, 1'b0);
        idle(5);
        rd(A_OUT0, 32'h0);

`ifdef GPIO_BANK_IRQ_EN
        // Pads held high through reset must not register as edges
        rd(A_IST0, 32'h0);
        rd(A_IST1, 32'h0);
        wr(A_IEN0, 4'hF, 32'h00000001);
        rd(A_IEN0, 32'h00000001);
        gpio_in[0] = 1'b1;
        idle(3);
        chk("irq_before_set", irq, 1'b0);
        rd(A_IST0, 32'h00000001);
        chk("irq_set", irq, 1'b1);
        wr(A_IST0, 4'hF, 32'h00000001);
        idle(1);
        chk("irq_cleared", irq, 1'b0);
        gpio_in[0] = 1'b0;
        idle(4);
        gpio_in[0] = 1'b1;
        idle(2);
        wr(A_IST0, 4'hF, 32'h00000001);
        idle(1);
        chk("irq_set_wins", irq, 1'b1);
        rd(A_IST0, 32'h00000001);
`else
        gpio_in[0] = 1'b0;
        idle(4);
        gpio_in[0] = 1'b1;
        idle(4);
        chk("irq_tied_low", irq, 1'b0);
        rd(A_IST0, 32'h0);
`endif

        idle(3);
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
